// File: rtl/hdp_pkg.sv
// Shared types and constants for the HDP-1280-2 register sequencer.
// HDP_INIT_SEQ_EN adds the power-up init states and table.
package hdp_pkg;

    localparam logic HDP_RD = 1'b1;
    localparam logic HDP_WR = 1'b0;

    localparam int HDP_INIT_MAX = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP,
        ST_RESPOND
`ifdef HDP_INIT_SEQ_EN
        ,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_INIT_GAP
`endif
    } hdp_state_e;

`ifdef HDP_INIT_SEQ_EN
    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } hdp_init_t;

    localparam hdp_init_t HDP_INIT_TABLE [HDP_INIT_MAX] = '{
        '{7'h01, 8'h80},
        '{7'h02, 8'h00},
        '{7'h03, 8'h1F},
        '{7'h10, 8'hC4},
        '{7'h11, 8'h07},
        '{7'h20, 8'h55},
        '{7'h21, 8'hAA},
        '{7'h7F, 8'h01}
    };
`endif

endpackage

// File: rtl/hdp_seq_timer.sv
// Loadable 16-bit down-counter saturating at zero.
// Shared by the transfer timeout and post-transfer gap phases.
module hdp_seq_timer (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [15:0] i_load_val,
    output logic        o_zero
);

    logic [15:0] r_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_zero = (r_count == 16'd0);

endmodule

// File: rtl/hdp_reg_sequencer.sv
// Register-access sequencer in front of the HDP-1280-2 SPI master.
// Define HDP_INIT_SEQ_EN to replay the power-up table before host commands.
module hdp_reg_sequencer
    import hdp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int GAP_CYCLES     = 1500,
    parameter int INIT_DEPTH     = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_rw,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_timeout,
    output logic                  o_spi_enable,
    output logic                  o_spi_start,
    output logic [7:0]            o_spi_tx_upper,
    output logic [7:0]            o_spi_tx_lower,
    input  logic [7:0]            i_spi_rx_lower,
    input  logic                  i_spi_complete,
    output logic                  o_init_done
);

    if (ADDR_WIDTH + 1 != 8 || DATA_WIDTH != 8 || GAP_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536 ||
        INIT_DEPTH < 1 || INIT_DEPTH > HDP_INIT_MAX) begin : g_bad_cfg
        $error("hdp_reg_sequencer: unsupported parameter set");
    end

    localparam logic [15:0] LD_TMO = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] LD_GAP = 16'(GAP_CYCLES - 1);

    hdp_state_e            r_state;
    logic                  r_rw;
    logic                  r_timeout;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_timeout;
    logic                  r_spi_enable;
    logic                  r_spi_start;
    logic [7:0]            r_tx_upper;
    logic [7:0]            r_tx_lower;
    logic                  r_init_done;
`ifdef HDP_INIT_SEQ_EN
    logic [2:0]            r_init_idx;
`endif

    logic        w_zero;
    logic        w_issue;
    logic        w_wait;
    logic        w_gap;
    logic        w_load;
    logic        w_en;
    logic [15:0] w_load_val;

    // Timer reloads on leaving ISSUE (timeout) and on leaving WAIT (gap).
    always_comb begin
        w_issue = (r_state == ST_ISSUE);
        w_wait  = (r_state == ST_WAIT_DONE);
        w_gap   = (r_state == ST_GAP);
`ifdef HDP_INIT_SEQ_EN
        w_issue = w_issue || ((r_state == ST_INIT_ISSUE) && r_spi_start);
        w_wait  = w_wait || (r_state == ST_INIT_WAIT);
        w_gap   = w_gap || (r_state == ST_INIT_GAP);
`endif
        w_load     = w_issue || (w_wait && (i_spi_complete || w_zero));
        w_load_val = w_issue ? LD_TMO : LD_GAP;
        w_en       = w_wait || w_gap;
    end

    hdp_seq_timer u_timer (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_load     (w_load),
        .i_en       (w_en),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
`ifdef HDP_INIT_SEQ_EN
            r_state    <= ST_INIT_ISSUE;
            r_init_idx <= 3'd0;
`else
            r_state    <= ST_IDLE;
`endif
            r_rw          <= 1'b0;
            r_timeout     <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_spi_enable  <= 1'b0;
            r_spi_start   <= 1'b0;
            r_tx_upper    <= 8'h00;
            r_tx_lower    <= 8'h00;
            r_init_done   <= 1'b0;
        end else begin
            r_spi_enable <= 1'b1;
            r_spi_start  <= 1'b0;
`ifndef HDP_INIT_SEQ_EN
            r_init_done  <= 1'b1;
`endif
            unique case (r_state)
                ST_IDLE: begin
                    if (r_cmd_ready && i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_rw        <= i_cmd_rw;
                        r_tx_upper  <= 8'({i_cmd_rw, i_cmd_addr});
                        r_tx_lower  <= (i_cmd_rw == HDP_WR) ?
                                       8'(i_cmd_data) : 8'h00;
                        r_spi_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_DONE;
                end
                // Completion wins over a simultaneous counter expiry.
                ST_WAIT_DONE: begin
                    if (i_spi_complete) begin
                        r_timeout <= 1'b0;
                        r_state   <= ST_GAP;
                    end else if (w_zero) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_zero) begin
                        r_rsp_data    <= (r_rw == HDP_RD && !r_timeout) ?
                                         DATA_WIDTH'(i_spi_rx_lower) : '0;
                        r_rsp_timeout <= r_timeout;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
`ifdef HDP_INIT_SEQ_EN
                // First cycle loads the frame, second carries the start pulse.
                ST_INIT_ISSUE: begin
                    if (!r_spi_start) begin
                        r_tx_upper  <= {HDP_WR, HDP_INIT_TABLE[r_init_idx].addr};
                        r_tx_lower  <= HDP_INIT_TABLE[r_init_idx].data;
                        r_spi_start <= 1'b1;
                    end else begin
                        r_state <= ST_INIT_WAIT;
                    end
                end
                ST_INIT_WAIT: begin
                    if (i_spi_complete || w_zero) begin
                        r_state <= ST_INIT_GAP;
                    end
                end
                ST_INIT_GAP: begin
                    if (w_zero) begin
                        if (r_init_idx == 3'(INIT_DEPTH - 1)) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_init_idx <= r_init_idx + 3'd1;
                            r_state    <= ST_INIT_ISSUE;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready    = r_cmd_ready;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_timeout  = r_rsp_timeout;
    assign o_spi_enable   = r_spi_enable;
    assign o_spi_start    = r_spi_start;
    assign o_spi_tx_upper = r_tx_upper;
    assign o_spi_tx_lower = r_tx_lower;
    assign o_init_done    = r_init_done;

endmodule

// File: doc/hdp_reg_sequencer.md
# hdp_reg_sequencer

Register-access sequencer sitting directly upstream of the HDP-1280-2 SPI master. It accepts register read/write commands over a valid/ready handshake and formats each one into the SPI master's 16-bit frame: `{rw, addr}` in the upper byte and `data` in the lower byte. It launches the transfer with a single-cycle start pulse, then waits for the master's completion pulse under a timeout. It returns read data, or a timeout flag, over a response handshake, and can optionally replay a fixed power-up register sequence before accepting host commands.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: register address width; upper SPI byte is `{rw, addr}`.
- `DATA_WIDTH`, 8: register data width.
- `TIMEOUT_CYCLES`, 20000: i_clock cycles allowed between start pulse and completion pulse.
- `GAP_CYCLES`, 1500: minimum idle i_clock cycles after completion before the next start. Lets the SPI master return to IDLE and update its Rx bytes.
- `INIT_DEPTH`, 8: number of entries in the power-up sequence.

Ports:
- `i_clock`, in, 1: system clock, the single clock of the block.
- `i_reset_n`, in, 1: reset, synchronous to `i_clock`, active-low.
- `i_cmd_valid` in 1, `o_cmd_ready` out 1: command handshake.
- `i_cmd_rw`, in, 1: 1 = read, 0 = write.
- `i_cmd_addr` in ADDR_WIDTH; `i_cmd_data` in DATA_WIDTH (ignored on read).
- `o_rsp_valid` out 1, `i_rsp_ready` in 1: response handshake.
- `o_rsp_data` out DATA_WIDTH; `o_rsp_timeout` out 1.
- `o_spi_enable`, out, 1: drives the SPI master's enable.
- `o_spi_start`, out, 1: drives the master's start_transfer.
- `o_spi_tx_upper` out 8; `o_spi_tx_lower` out 8: drive the master's Tx bytes.
- `i_spi_rx_lower`, in, 8: from the master's Rx lower byte.
- `i_spi_complete`, in, 1: from the master's one-cycle completion pulse.
- `o_init_done`, out, 1: power-up sequence finished.

## Operation
- States:
  - IDLE: `o_cmd_ready` = 1 only here, with init done and no response pending.
  - ISSUE: one cycle, `o_spi_start` = 1.
  - WAIT_DONE: wait for completion or timeout.
  - GAP: enforce the post-transfer idle gap.
  - RESPOND: hold the response.
  - INIT_ISSUE / INIT_WAIT / INIT_GAP: only with the macro.
- IDLE -> ISSUE on `i_cmd_valid && o_cmd_ready`. At this point:
  - latch `o_spi_tx_upper` = `{i_cmd_rw, i_cmd_addr}`;
  - latch `o_spi_tx_lower` = write ? `i_cmd_data` : 8'h00;
  - latch rw.
- ISSUE -> WAIT_DONE unconditionally. The down-counter loads TIMEOUT_CYCLES-1.
- WAIT_DONE -> GAP when `i_spi_complete` = 1, with timeout flag cleared.
- WAIT_DONE -> GAP when the counter reaches 0 first, with timeout flag set.
- GAP counts GAP_CYCLES. It then goes to RESPOND, latching:
  - `o_rsp_data` = (read && !timeout) ? `i_spi_rx_lower` : 0;
  - `o_rsp_timeout` = timeout flag.
- RESPOND: `o_rsp_valid` = 1. Data and flag stay stable until `i_rsp_ready`; then go to IDLE.
- `i_spi_complete` is ignored in every state except WAIT_DONE.
- A stale completion arriving after a timeout or a reset is dropped.
- `o_spi_tx_*` hold their values from ISSUE until the next ISSUE.
- `o_spi_enable` = 0 in reset, 1 from the first cycle after reset is released.

## Timing
- Reset values while `i_reset_n` = 0 (sampled on `i_clock`):
  - `o_cmd_ready`, `o_rsp_valid`, `o_rsp_timeout`, `o_spi_start`, `o_spi_enable`, `o_init_done` = 0;
  - `o_rsp_data`, `o_spi_tx_upper`, `o_spi_tx_lower` = 0;
  - state = IDLE (or INIT_ISSUE with the macro);
  - counter = 0.
- Reset mid-transfer aborts immediately. No response is produced for the aborted command.
- `o_spi_start` is exactly one cycle wide. It is never reasserted within GAP_CYCLES of a completion or timeout.
- Accept-to-start latency: the start pulse comes 1 cycle after the handshake.
- Completion-to-`o_rsp_valid` latency: exactly GAP_CYCLES+1 cycles.
- Throughput: one outstanding command; `o_cmd_ready` is low from accept until the response is taken.
- Timeout boundary: a completion in the same cycle as counter = 0 counts as success.
- Counter: 16 bits, saturating at 0.

## Configuration
- `HDP_INIT_SEQ_EN` defined:
  - after reset, the block writes INIT_DEPTH `{addr, data}` entries from the package table through the INIT states, in index order;
  - the same ISSUE/WAIT/GAP timing applies;
  - no responses are emitted;
  - a timeout skips to the next entry;
  - `o_init_done` rises 1 cycle after the last INIT_GAP and stays high until reset;
  - `o_cmd_ready` is low until then.
- Not defined:
  - INIT states and table are absent;
  - `o_init_done` = 1 from the first cycle after reset release.

## Structure
- `hdp_pkg` holds:
  - the state enum;
  - the RW bit constants (HDP_RD = 1, HDP_WR = 0);
  - the INIT_DEPTH-entry init table as a constant array of `{addr, data}`.
- One sub-module, `hdp_seq_timer`: a loadable 16-bit down-counter with load, enable and `zero` output. It is shared by the timeout and gap phases.

## Test plan
- Write addr 0x12 data 0xA5; pulse complete 8000 cycles after start. Required:
  - `o_spi_tx_upper` = 0x12, `o_spi_tx_lower` = 0xA5;
  - one-cycle start pulse;
  - `o_rsp_valid` exactly GAP_CYCLES+1 cycles after complete, with data 0x00 and timeout 0.
- Read addr 0x05, `i_spi_rx_lower` = 0x3C at the end of GAP. Required: `o_spi_tx_upper` = 0x85, `o_spi_tx_lower` = 0x00, `o_rsp_data` = 0x3C.
- Never pulse complete. Required: `o_rsp_timeout` = 1 and data 0, GAP_CYCLES+1 cycles after TIMEOUT_CYCLES elapse. A late complete pulse afterwards causes no effect.
- Hold `i_rsp_ready` = 0 for 100 cycles. Required: `o_rsp_valid`, data and flag stable throughout; `o_cmd_ready` = 0; no start pulse.
- Assert `i_reset_n` = 0 during WAIT_DONE, then pulse complete after release. Required: all outputs at reset values, no response produced, the next command works normally.
- With `HDP_INIT_SEQ_EN`, auto-complete every transfer. Required: 8 start pulses carrying the table entries in order, `o_cmd_ready` = 0 throughout, `o_init_done` rising after the 8th gap.
